// File: rtl/alu_join_skid_stage_if.sv
// Handshake bundle for alu_join_skid_stage: two joined operand channels in, one result
// channel out, plus the retired-result counter.
interface alu_join_skid_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             v_i1;
    logic [WIDTH-1:0] data_i1;
    logic [2:0]       op_i1;
    logic             stall_o1;
    logic             v_i2;
    logic [WIDTH-1:0] data_i2;
    logic             stall_o2;
    logic             v_o;
    logic [WIDTH-1:0] data_o;
    logic [1:0]       flag_o;
    logic             stall_i;
    logic [CNT_W-1:0] retired_o;

    // Environment side: produces operands, consumes results.
    modport master (
        output v_i1, data_i1, op_i1, v_i2, data_i2, stall_i,
        input  stall_o1, stall_o2, v_o, data_o, flag_o, retired_o
    );

    // Stage side.
    modport slave (
        input  v_i1, data_i1, op_i1, v_i2, data_i2, stall_i,
        output stall_o1, stall_o2, v_o, data_o, flag_o, retired_o
    );
endinterface

// File: rtl/alu_join_skid_stage.sv
// Two-channel join feeding an 8-op ALU, with a main+skid output buffer so the upstream
// stalls depend only on registered state, never on stall_i.
module alu_join_skid_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    alu_join_skid_stage_if.slave bus
);
    localparam int unsigned ShW = $clog2(WIDTH);
    localparam int unsigned Msb = WIDTH - 1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] head_data_q, skid_data_q;
    logic [1:0]       head_flag_q, skid_flag_q;
    logic [CNT_W-1:0] retired_q;

    logic             full, fire, pop;
    logic [WIDTH-1:0] a, b, res;
    logic [ShW-1:0]   sh;
    logic             ovf;
    logic [1:0]       flag;

    assign a    = bus.data_i1;
    assign b    = bus.data_i2;
    assign sh   = b[ShW-1:0];
    assign full = (state_q == StFull);
    assign fire = bus.v_i1 & bus.v_i2 & ~full;
    assign pop  = (state_q != StEmpty) & ~bus.stall_i;

    // Neither channel is consumed alone; reset forces both stalls high.
    assign bus.stall_o1 = ~reset | full | ~bus.v_i2;
    assign bus.stall_o2 = ~reset | full | ~bus.v_i1;

    assign bus.v_o       = (state_q != StEmpty);
    assign bus.data_o    = head_data_q;
    assign bus.flag_o    = head_flag_q;
    assign bus.retired_o = retired_q;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (bus.op_i1)
            3'b000: begin
                res = a + b;
                ovf = (a[Msb] == b[Msb]) && (res[Msb] != a[Msb]);
            end
            3'b001: begin
                res = a - b;
                ovf = (a[Msb] != b[Msb]) && (res[Msb] != a[Msb]);
            end
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b100:  res = a ^ b;
            3'b101:  res = a << sh;
            3'b110:  res = a >> sh;
            default: res = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
        flag = {(res == '0), ovf};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            head_data_q <= '0;
            head_flag_q <= '0;
            skid_data_q <= '0;
            skid_flag_q <= '0;
            retired_q   <= '0;
        end else begin
            if (pop) begin
                retired_q <= retired_q + CntOne;
            end
            unique case (state_q)
                StEmpty: begin
                    if (fire) begin
                        state_q     <= StOne;
                        head_data_q <= res;
                        head_flag_q <= flag;
                    end
                end
                StOne: begin
                    if (fire && pop) begin
                        head_data_q <= res;
                        head_flag_q <= flag;
                    end else if (fire) begin
                        state_q     <= StFull;
                        skid_data_q <= res;
                        skid_flag_q <= flag;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    // Skid moves up to head; fire cannot occur while full.
                    if (pop) begin
                        state_q     <= StOne;
                        head_data_q <= skid_data_q;
                        head_flag_q <= skid_flag_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_join_skid_stage.sv
// Directed and randomised checks of alu_join_skid_stage: ALU results, flags, join,
// skid buffering, FIFO ordering under back-pressure, retired counter and async reset.
module tb_alu_join_skid_stage;
    localparam int unsigned W = 32;
    localparam int unsigned CW = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [CW-1:0] exp_ret;

    alu_join_skid_stage_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    alu_join_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result plus {zero, signed overflow} from a widened signed computation.
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint     sa, sb, s;
        logic [31:0] r;
        logic       ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        ov = 1'b0;
        case (op)
            3'd0: begin
                s  = sa + sb;
                r  = a + b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                s  = sa - sb;
                r  = a - b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << b[4:0];
            3'd6:    r = a >> b[4:0];
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        return {(r == 32'd0), ov, r};
    endfunction

    task automatic test_reset();
        reset       = 1'b0;
        bus.v_i1    = 1'b1;
        bus.v_i2    = 1'b1;
        bus.data_i1 = 32'd1;
        bus.data_i2 = 32'd2;
        bus.op_i1   = 3'd0;
        bus.stall_i = 1'b0;
        @(negedge clk);
        total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL rst_v_o: got %b want 0", bus.v_o); end
        total++; if (bus.data_o !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.data_o); end
        total++; if (bus.flag_o !== 2'b00) begin bad++; $display("FAIL rst_flag: got %b want 00", bus.flag_o); end
        total++; if (bus.retired_o !== 4'd0) begin bad++; $display("FAIL rst_retired: got %0d want 0", bus.retired_o); end
        total++; if (bus.stall_o1 !== 1'b1) begin bad++; $display("FAIL rst_stall1: got %b want 1", bus.stall_o1); end
        total++; if (bus.stall_o2 !== 1'b1) begin bad++; $display("FAIL rst_stall2: got %b want 1", bus.stall_o2); end
        bus.v_i1 = 1'b0;
        bus.v_i2 = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL rst_release_v_o: got %b want 0", bus.v_o); end
        exp_ret = '0;
    endtask

    task automatic test_ops();
        logic [31:0] exp_d [8];
        exp_d[0] = 32'd8;  exp_d[1] = 32'd2; exp_d[2] = 32'd1; exp_d[3] = 32'd7;
        exp_d[4] = 32'd6;  exp_d[5] = 32'd40; exp_d[6] = 32'd0; exp_d[7] = 32'd0;
        bus.data_i1 = 32'd5;
        bus.data_i2 = 32'd3;
        bus.stall_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                bus.v_i1  = 1'b1;
                bus.v_i2  = 1'b1;
                bus.op_i1 = 3'(i);
            end else begin
                bus.v_i1 = 1'b0;
                bus.v_i2 = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL ops_v_o[%0d]: got %b want 1", i - 1, bus.v_o); end
                total++; if (bus.data_o !== exp_d[i-1]) begin bad++; $display("FAIL ops_data[%0d]: got %0d want %0d", i - 1, bus.data_o, exp_d[i-1]); end
            end
            @(posedge clk); #1;
        end
        exp_ret = exp_ret + 4'd8;
        total++; if (bus.retired_o !== 4'd8) begin bad++; $display("FAIL ops_retired: got %0d want 8", bus.retired_o); end
        total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL ops_drained: got %b want 0", bus.v_o); end
    endtask

    task automatic test_flags();
        bus.v_i1 = 1'b1; bus.v_i2 = 1'b1;
        bus.op_i1 = 3'd1; bus.data_i1 = 32'd5; bus.data_i2 = 32'd5;
        @(posedge clk); #1;
        bus.op_i1 = 3'd0; bus.data_i1 = 32'h7FFF_FFFF; bus.data_i2 = 32'd1;
        total++; if ({bus.v_o, bus.data_o} !== {1'b1, 32'd0}) begin bad++; $display("FAIL sub_data: got %b/%h want 1/0", bus.v_o, bus.data_o); end
        total++; if (bus.flag_o !== 2'b10) begin bad++; $display("FAIL sub_flag: got %b want 10", bus.flag_o); end
        @(posedge clk); #1;
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0;
        total++; if (bus.data_o !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf_data: got %h want 80000000", bus.data_o); end
        total++; if (bus.flag_o !== 2'b01) begin bad++; $display("FAIL add_ovf_flag: got %b want 01", bus.flag_o); end
        @(posedge clk); #1;
        exp_ret = exp_ret + 4'd2;
        total++; if ({bus.v_o, bus.data_o, bus.flag_o} !== {1'b0, 32'h8000_0000, 2'b01}) begin
            bad++; $display("FAIL hold_after_pop: got %b/%h/%b want 0/80000000/01", bus.v_o, bus.data_o, bus.flag_o);
        end
    endtask

    task automatic test_join();
        bus.v_i1 = 1'b1; bus.v_i2 = 1'b0;
        bus.op_i1 = 3'd0; bus.data_i1 = 32'd10; bus.data_i2 = 32'd20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.stall_o1 !== 1'b1) begin bad++; $display("FAIL join_stall1[%0d]: got %b want 1", i, bus.stall_o1); end
            total++; if (bus.stall_o2 !== 1'b0) begin bad++; $display("FAIL join_stall2[%0d]: got %b want 0", i, bus.stall_o2); end
            total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL join_v_o[%0d]: got %b want 0", i, bus.v_o); end
            @(posedge clk); #1;
        end
        bus.v_i2 = 1'b1;
        @(negedge clk);
        total++; if (bus.stall_o1 !== 1'b0) begin bad++; $display("FAIL join_fire: got stall %b want 0", bus.stall_o1); end
        @(posedge clk); #1;
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0;
        total++; if ({bus.v_o, bus.data_o} !== {1'b1, 32'd30}) begin bad++; $display("FAIL join_result: got %b/%0d want 1/30", bus.v_o, bus.data_o); end
        @(posedge clk); #1;
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic test_skid();
        bus.stall_i = 1'b1;
        bus.v_i1 = 1'b1; bus.v_i2 = 1'b1;
        bus.op_i1 = 3'd0; bus.data_i2 = 32'd0; bus.data_i1 = 32'd101;
        @(negedge clk);
        total++; if (bus.stall_o1 !== 1'b0) begin bad++; $display("FAIL skid_fire0: got stall %b want 0", bus.stall_o1); end
        @(posedge clk); #1;
        bus.data_i1 = 32'd102;
        @(negedge clk);
        total++; if (bus.stall_o1 !== 1'b0) begin bad++; $display("FAIL skid_fire1: got stall %b want 0", bus.stall_o1); end
        @(posedge clk); #1;
        bus.data_i1 = 32'd103;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if ({bus.stall_o1, bus.stall_o2} !== 2'b11) begin bad++; $display("FAIL skid_full_stall[%0d]: got %b want 11", i, {bus.stall_o1, bus.stall_o2}); end
            total++; if ({bus.v_o, bus.data_o} !== {1'b1, 32'd101}) begin bad++; $display("FAIL skid_hold[%0d]: got %b/%0d want 1/101", i, bus.v_o, bus.data_o); end
            @(posedge clk); #1;
        end
        bus.stall_i = 1'b0;
        @(negedge clk);
        total++; if (bus.stall_o1 !== 1'b1) begin bad++; $display("FAIL skid_release_stall: got %b want 1", bus.stall_o1); end
        total++; if (bus.data_o !== 32'd101) begin bad++; $display("FAIL skid_out0: got %0d want 101", bus.data_o); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({bus.data_o, bus.stall_o1} !== {32'd102, 1'b0}) begin bad++; $display("FAIL skid_out1: got %0d/%b want 102/0", bus.data_o, bus.stall_o1); end
        @(posedge clk); #1;
        bus.data_i1 = 32'd104;
        total++; if (bus.data_o !== 32'd103) begin bad++; $display("FAIL skid_out2: got %0d want 103", bus.data_o); end
        @(posedge clk); #1;
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0;
        total++; if ({bus.v_o, bus.data_o} !== {1'b1, 32'd104}) begin bad++; $display("FAIL skid_out3: got %b/%0d want 1/104", bus.v_o, bus.data_o); end
        @(posedge clk); #1;
        exp_ret = exp_ret + 4'd4;
        total++; if ({bus.v_o, bus.retired_o} !== {1'b0, exp_ret}) begin bad++; $display("FAIL skid_drain: got %b/%0d want 0/%0d", bus.v_o, bus.retired_o, exp_ret); end
    endtask

    task automatic test_wrap();
        bus.v_i1 = 1'b1; bus.v_i2 = 1'b1;
        bus.op_i1 = 3'd0; bus.data_i1 = 32'd7; bus.data_i2 = 32'd0;
        @(posedge clk); #1;
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0;
        @(posedge clk); #1;
        exp_ret = exp_ret + 4'd1;
        total++; if (bus.retired_o !== 4'd0) begin bad++; $display("FAIL retired_wrap: got %0d want 0", bus.retired_o); end
    endtask

    task automatic test_random();
        logic [33:0] q[$];
        logic        f;
        logic        p;
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0; bus.stall_i = 1'b0;
        for (int cyc = 0; cyc < 1010; cyc++) begin
            @(negedge clk);
            total++; if (bus.v_o !== (q.size() != 0)) begin bad++; $display("FAIL rnd_v_o@%0d: got %b want %b", cyc, bus.v_o, q.size() != 0); end
            total++; if (bus.stall_o1 !== (q.size() == 2 || !bus.v_i2)) begin bad++; $display("FAIL rnd_stall1@%0d: got %b", cyc, bus.stall_o1); end
            total++; if (bus.stall_o2 !== (q.size() == 2 || !bus.v_i1)) begin bad++; $display("FAIL rnd_stall2@%0d: got %b", cyc, bus.stall_o2); end
            f = bus.v_i1 && bus.v_i2 && (q.size() < 2);
            p = (q.size() != 0) && !bus.stall_i;
            if (p) begin
                total++;
                if ({bus.flag_o, bus.data_o} !== q[0]) begin
                    bad++; $display("FAIL rnd_result@%0d: got %b/%h want %b/%h", cyc, bus.flag_o, bus.data_o, q[0][33:32], q[0][31:0]);
                end
                void'(q.pop_front());
                exp_ret = exp_ret + 4'd1;
            end
            if (f) q.push_back(alu_ref(bus.data_i1, bus.data_i2, bus.op_i1));
            @(posedge clk); #1;
            if (cyc >= 1000) begin
                bus.v_i1 = 1'b0; bus.v_i2 = 1'b0; bus.stall_i = 1'b0;
            end else begin
                bus.stall_i = ($urandom_range(0, 2) == 0);
                if (!bus.v_i1 || f) begin
                    bus.v_i1    = ($urandom_range(0, 3) != 0);
                    bus.data_i1 = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
                    bus.op_i1   = 3'($urandom_range(0, 7));
                end
                if (!bus.v_i2 || f) begin
                    bus.v_i2    = ($urandom_range(0, 3) != 0);
                    bus.data_i2 = ($urandom_range(0, 7) == 0) ? bus.data_i1 : $urandom;
                end
            end
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_lost: got %0d undelivered want 0", q.size()); end
        total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL rnd_retired: got %0d want %0d", bus.retired_o, exp_ret); end
    endtask

    task automatic test_reset_mid();
        bus.stall_i = 1'b1;
        bus.v_i1 = 1'b1; bus.v_i2 = 1'b1;
        bus.op_i1 = 3'd0; bus.data_i1 = 32'd1; bus.data_i2 = 32'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if ({bus.stall_o1, bus.stall_o2} !== 2'b11) begin bad++; $display("FAIL mid_full: got %b want 11", {bus.stall_o1, bus.stall_o2}); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL mid_async_v_o: got %b want 0", bus.v_o); end
        total++; if (bus.retired_o !== 4'd0) begin bad++; $display("FAIL mid_retired: got %0d want 0", bus.retired_o); end
        bus.stall_i = 1'b0;
        @(posedge clk); #1;
        total++; if ({bus.stall_o1, bus.stall_o2, bus.v_o} !== 3'b110) begin bad++; $display("FAIL mid_in_reset: got %b want 110", {bus.stall_o1, bus.stall_o2, bus.v_o}); end
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL mid_empty_after: got %b want 0", bus.v_o); end
        bus.v_i1 = 1'b1; bus.v_i2 = 1'b1;
        bus.op_i1 = 3'd1; bus.data_i1 = 32'd9; bus.data_i2 = 32'd4;
        @(posedge clk); #1;
        bus.v_i1 = 1'b0; bus.v_i2 = 1'b0;
        total++; if ({bus.v_o, bus.data_o} !== {1'b1, 32'd5}) begin bad++; $display("FAIL mid_restart: got %b/%0d want 1/5", bus.v_o, bus.data_o); end
        @(posedge clk); #1;
        total++; if (bus.retired_o !== 4'd1) begin bad++; $display("FAIL mid_retired_restart: got %0d want 1", bus.retired_o); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_ret = '0;
        test_reset();
        test_ops();
        test_flags();
        test_join();
        test_skid();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
